// File: rtl/ccu_pkg.sv
// Shared CCU definitions: packet type bytes, header geometry and the TX arbiter
// state encoding, plus the header byte selector used by the arbiter.
package ccu_pkg;

  localparam logic [7:0] PACKAGE_TYPE_SYS_ACK      = 8'h00;
  localparam logic [7:0] PACKAGE_TYPE_DAC_WR_ACK   = 8'h11;
  localparam logic [7:0] PACKAGE_TYPE_ADC_DATA     = 8'h12;
  localparam logic [7:0] PACKAGE_TYPE_DAC_READBACK = 8'h21;
  localparam logic [7:0] PACKAGE_TYPE_ADC_CFG_ACK  = 8'h22;

  localparam int CCU_HDR_LEN = 5;
  localparam int CCU_LEN_W   = 13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } tx_arb_state_e;

  // Header layout: type, id high, id low, length high (5 bits), length low.
  function automatic logic [7:0] hdr_byte(input logic [2:0]           idx,
                                          input logic [7:0]           ptype,
                                          input logic [15:0]          id,
                                          input logic [CCU_LEN_W-1:0] len);
    case (idx)
      3'd0:    hdr_byte = ptype;
      3'd1:    hdr_byte = id[15:8];
      3'd2:    hdr_byte = id[7:0];
      3'd3:    hdr_byte = {3'b000, len[12:8]};
      default: hdr_byte = len[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ccu_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module ccu_rr_arb #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  localparam logic [PTR_W:0] N_W = (PTR_W + 1)'(N);
  localparam logic [N-1:0]   ONE = {{(N-1){1'b0}}, 1'b1};

  logic [PTR_W:0] back_sh;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_oh;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign back_sh = N_W - {1'b0, ptr};
  assign rot     = (req >> ptr) | (req << back_sh);
  assign rot_oh  = rot & ~(rot - ONE);
  assign grant   = (rot_oh << ptr) | (rot_oh >> back_sh);
  assign valid   = |req;

endmodule

// File: rtl/ccu_tx_arb.sv
// Round-robin packet scheduler onto the SPI TX stream: registered 5-byte header
// followed by a length-bounded combinational passthrough of the granted source.
module ccu_tx_arb
  import ccu_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int LEN_W   = 13
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [8*NUM_SRC-1:0]     src_type,
  input  logic [LEN_W*NUM_SRC-1:0] src_len,
  output logic [NUM_SRC-1:0]       src_grant,
  input  logic [8*NUM_SRC-1:0]     src_axis_tdata,
  input  logic [NUM_SRC-1:0]       src_axis_tvalid,
  output logic [NUM_SRC-1:0]       src_axis_tready,
  input  logic [NUM_SRC-1:0]       src_axis_tlast,
  output logic [7:0]               spi_send_axis_tdata,
  output logic                     spi_send_axis_tvalid,
  input  logic                     spi_send_axis_tready,
  output logic                     spi_send_axis_tlast,
  output logic                     busy,
  output logic                     err_len
);

  localparam int               PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [2:0]       HDR_LAST = 3'(CCU_HDR_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  tx_arb_state_e      state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        pack_id_q, pack_id_d;
  logic [7:0]         type_q, type_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [2:0]         hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic [7:0]         hdr_data_q, hdr_data_d;
  logic               hdr_valid_q, hdr_valid_d;
  logic               hdr_last_q, hdr_last_d;
  logic               err_len_q, err_len_d;

  logic [NUM_SRC-1:0] win;
  logic               win_valid;
  logic [PTR_W-1:0]   ptr_adv;
  logic [7:0]         win_type [NUM_SRC];
  logic [LEN_W-1:0]   win_len  [NUM_SRC];
  logic [7:0]         gnt_data [NUM_SRC];
  logic [7:0]         sel_type, sel_data;
  logic [LEN_W-1:0]   sel_len;
  logic               gnt_valid, gnt_last, pay_active, pay_last;
  logic [2:0]         hdr_nxt;

  ccu_rr_arb #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr_arb (
    .req   (src_req),
    .ptr   (ptr_q),
    .grant (win),
    .valid (win_valid)
  );

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign win_type[gi]        = src_type[gi*8 +: 8] & {8{win[gi]}};
    assign win_len[gi]         = src_len[gi*LEN_W +: LEN_W] & {LEN_W{win[gi]}};
    assign gnt_data[gi]        = src_axis_tdata[gi*8 +: 8] & {8{grant_q[gi]}};
    assign src_axis_tready[gi] = pay_active & grant_q[gi] & spi_send_axis_tready;
  end

  always_comb begin
    sel_type = '0;
    sel_len  = '0;
    sel_data = '0;
    ptr_adv  = ptr_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_type = sel_type | win_type[i];
      sel_len  = sel_len | win_len[i];
      sel_data = sel_data | gnt_data[i];
      if (win[i]) ptr_adv = (i == NUM_SRC - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  assign gnt_valid  = |(src_axis_tvalid & grant_q);
  assign gnt_last   = |(src_axis_tlast & grant_q);
  assign pay_active = (state_q == ST_PAYLOAD);
  assign pay_last   = (pay_cnt_q == LEN_ONE);
  assign hdr_nxt    = hdr_cnt_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    pack_id_d   = pack_id_q;
    type_d      = type_q;
    len_d       = len_q;
    hdr_cnt_d   = hdr_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    hdr_data_d  = hdr_data_q;
    hdr_valid_d = hdr_valid_q;
    hdr_last_d  = hdr_last_q;
    err_len_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d     = ST_HDR;
          grant_d     = win;
          ptr_d       = ptr_adv;
          type_d      = sel_type;
          len_d       = sel_len;
          hdr_cnt_d   = 3'd0;
          hdr_data_d  = sel_type;
          hdr_valid_d = 1'b1;
          hdr_last_d  = 1'b0;
        end
      end
      ST_HDR: begin
        if (spi_send_axis_tready) begin
          if (hdr_cnt_q == HDR_LAST) begin
            pack_id_d   = pack_id_q + 16'd1;
            hdr_data_d  = '0;
            hdr_valid_d = 1'b0;
            hdr_last_d  = 1'b0;
            if (len_q == '0) begin
              state_d = ST_IDLE;
              grant_d = '0;
            end else begin
              state_d   = ST_PAYLOAD;
              pay_cnt_d = len_q;
            end
          end else begin
            hdr_cnt_d  = hdr_nxt;
            hdr_data_d = hdr_byte(hdr_nxt, type_q, pack_id_q, CCU_LEN_W'(len_q));
            hdr_last_d = (hdr_nxt == HDR_LAST) && (len_q == '0);
          end
        end
      end
      ST_PAYLOAD: begin
        if (gnt_valid && spi_send_axis_tready) begin
          pay_cnt_d = pay_cnt_q - LEN_ONE;
          // Either the count or the source's tlast ends the packet; disagreement flags an error.
          if (pay_last || gnt_last) begin
            state_d   = ST_IDLE;
            grant_d   = '0;
            err_len_d = pay_last ? ~gnt_last : 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      pack_id_q   <= '0;
      type_q      <= '0;
      len_q       <= '0;
      hdr_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      hdr_data_q  <= '0;
      hdr_valid_q <= 1'b0;
      hdr_last_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      pack_id_q   <= pack_id_d;
      type_q      <= type_d;
      len_q       <= len_d;
      hdr_cnt_q   <= hdr_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      hdr_data_q  <= hdr_data_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_last_q  <= hdr_last_d;
      err_len_q   <= err_len_d;
    end
  end

  assign src_grant            = grant_q;
  assign spi_send_axis_tdata  = pay_active ? sel_data : hdr_data_q;
  assign spi_send_axis_tvalid = pay_active ? gnt_valid : hdr_valid_q;
  assign spi_send_axis_tlast  = pay_active ? (pay_last | gnt_last) : hdr_last_q;
  assign busy                 = (state_q != ST_IDLE);
  assign err_len              = err_len_q;

endmodule

// File: tb/tb_ccu_tx_arb.sv
// Randomized bench for ccu_tx_arb: a packet-level model predicts grant order,
// the full output byte stream, length errors and bytes consumed per source.
module tb_ccu_tx_arb;

  localparam int N  = 3;
  localparam int LW = 13;

  logic            axi_aclk = 1'b0;
  logic            axi_aresetn;
  logic [N-1:0]    src_req;
  logic [8*N-1:0]  src_type;
  logic [LW*N-1:0] src_len;
  logic [N-1:0]    src_grant;
  logic [8*N-1:0]  src_axis_tdata;
  logic [N-1:0]    src_axis_tvalid;
  logic [N-1:0]    src_axis_tready;
  logic [N-1:0]    src_axis_tlast;
  logic [7:0]      spi_send_axis_tdata;
  logic            spi_send_axis_tvalid;
  logic            spi_send_axis_tready;
  logic            spi_send_axis_tlast;
  logic            busy;
  logic            err_len;

  ccu_tx_arb #(.NUM_SRC(N), .LEN_W(LW)) dut (
    .axi_aclk             (axi_aclk),
    .axi_aresetn          (axi_aresetn),
    .src_req              (src_req),
    .src_type             (src_type),
    .src_len              (src_len),
    .src_grant            (src_grant),
    .src_axis_tdata       (src_axis_tdata),
    .src_axis_tvalid      (src_axis_tvalid),
    .src_axis_tready      (src_axis_tready),
    .src_axis_tlast       (src_axis_tlast),
    .spi_send_axis_tdata  (spi_send_axis_tdata),
    .spi_send_axis_tvalid (spi_send_axis_tvalid),
    .spi_send_axis_tready (spi_send_axis_tready),
    .spi_send_axis_tlast  (spi_send_axis_tlast),
    .busy                 (busy),
    .err_len              (err_len)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       h;
  } exp_t;

  int n_cmp = 0;
  int n_err = 0;

  // Packet-level reference state
  int   m_ptr = 0;
  int   m_id  = 0;
  int   m_errs;
  int   exp_cons [N];
  exp_t exp_q [$];
  int   ord_q [$];

  // Per-source stimulus configuration and runtime
  bit         cfg_on [N];
  int         cfg_len [N];
  int         cfg_lastpos [N];
  logic [7:0] cfg_type [N];
  logic [7:0] cfg_data [N][16];
  bit         s_act [N];
  int         s_pos [N];
  bit         s_vld [N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input int s);
    return (cfg_lastpos[s] > 0) ? cfg_lastpos[s] : cfg_len[s] + 2;
  endfunction

  task automatic drive_sources();
    for (int s = 0; s < N; s++) begin
      int p;
      p = (s_pos[s] < 16) ? s_pos[s] : 15;
      src_type[s*8 +: 8]       = cfg_type[s];
      src_len[s*LW +: LW]      = LW'(cfg_len[s]);
      src_axis_tdata[s*8 +: 8] = cfg_data[s][p];
      src_axis_tvalid[s]       = s_act[s] && s_vld[s] && (s_pos[s] < nbytes(s));
      src_axis_tlast[s]        = (cfg_lastpos[s] > 0) && (s_pos[s] == cfg_lastpos[s] - 1);
    end
  endtask

  task automatic clear_cfg();
    for (int s = 0; s < N; s++) begin
      cfg_on[s] = 1'b0; cfg_len[s] = 0; cfg_lastpos[s] = 0; cfg_type[s] = 8'h00;
      for (int i = 0; i < 16; i++) cfg_data[s][i] = 8'h00;
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input logic h);
    exp_t e;
    e.d = d; e.l = l; e.h = h;
    exp_q.push_back(e);
  endtask

  // Serve all pending sources in round-robin order from the model pointer.
  task automatic build_model();
    bit pend [N];
    int w, c;
    logic [15:0] id;
    logic [12:0] ln;
    m_errs = 0;
    for (int s = 0; s < N; s++) begin pend[s] = cfg_on[s]; exp_cons[s] = 0; end
    for (int pk = 0; pk < N; pk++) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (w < 0 && pend[idx]) w = idx;
      end
      if (w < 0) break;
      pend[w] = 1'b0;
      ord_q.push_back(w);
      m_ptr = (w + 1) % N;
      id = m_id[15:0];
      ln = cfg_len[w][12:0];
      push_exp(cfg_type[w], 1'b0, 1'b1);
      push_exp(id[15:8], 1'b0, 1'b1);
      push_exp(id[7:0], 1'b0, 1'b1);
      push_exp({3'b000, ln[12:8]}, 1'b0, 1'b1);
      push_exp(ln[7:0], cfg_len[w] == 0, 1'b1);
      m_id = (m_id + 1) % 65536;
      c = (cfg_lastpos[w] > 0 && cfg_lastpos[w] < cfg_len[w]) ? cfg_lastpos[w] : cfg_len[w];
      if (cfg_len[w] > 0 && cfg_lastpos[w] != cfg_len[w]) m_errs++;
      for (int i = 0; i < c; i++) push_exp(cfg_data[w][i], i == c - 1, 1'b0);
      exp_cons[w] = c;
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_val({pfx, "_grant"}, 32'(src_grant), 0);
    check_val({pfx, "_src_tready"}, 32'(src_axis_tready), 0);
    check_val({pfx, "_tvalid"}, 32'(spi_send_axis_tvalid), 0);
    check_val({pfx, "_tdata"}, 32'(spi_send_axis_tdata), 0);
    check_val({pfx, "_tlast"}, 32'(spi_send_axis_tlast), 0);
    check_val({pfx, "_busy"}, 32'(busy), 0);
    check_val({pfx, "_err_len"}, 32'(err_len), 0);
  endtask

  task automatic reset_model();
    m_ptr = 0; m_id = 0;
    exp_q.delete(); ord_q.delete();
  endtask

  task automatic do_reset();
    axi_aresetn = 1'b0;
    src_req     = '0;
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    reset_model();
  endtask

  // Entered and left just after a rising edge.
  task automatic run_phase(input bit bp, input int abort_cyc);
    int cyc, last_end, errs_seen, g, cur_src;
    bit first, stall_prev;
    logic [N-1:0] prev_g, hs, exp_rdy;
    logic [7:0] prev_d;
    logic prev_l;
    exp_t e;
    build_model();
    for (int s = 0; s < N; s++) begin
      s_pos[s] = 0; s_act[s] = cfg_on[s];
      s_vld[s] = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_req[s] = cfg_on[s];
    end
    spi_send_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_sources();
    prev_g = '0; first = 1'b1; cyc = -1; errs_seen = 0; stall_prev = 1'b0;
    last_end = 0; cur_src = 0; prev_d = '0; prev_l = 1'b0;
    while (1) begin
      @(negedge axi_aclk);
      cyc++;
      check_val("grant_onehot0", 32'($onehot0(src_grant)), 1);
      check_val("busy_vs_grant", 32'(busy), 32'(|src_grant));
      if (src_grant != '0 && prev_g == '0) begin
        g = -1;
        for (int k = 0; k < N; k++) if (src_grant[k]) g = k;
        cur_src = (ord_q.size() > 0) ? ord_q.pop_front() : 99;
        check_val("grant_src", g, cur_src);
        if (first) check_val("req_to_grant_lat", cyc, 1);
        else       check_val("idle_gap", cyc - last_end, 2);
        first = 1'b0;
        check_val("hdr_valid_at_grant", 32'(spi_send_axis_tvalid), 1);
        $display("pkt: src %0d granted at cycle %0d", g, cyc);
      end
      for (int s = 0; s < N; s++) if (prev_g[s] && !src_grant[s]) s_act[s] = 1'b0;
      exp_rdy = '0;
      if (exp_q.size() > 0 && !exp_q[0].h && cur_src < N) exp_rdy[cur_src] = spi_send_axis_tready;
      check_val("src_tready", 32'(src_axis_tready), 32'(exp_rdy));
      if (stall_prev) begin
        check_val("stall_tvalid", 32'(spi_send_axis_tvalid), 1);
        check_val("stall_tdata", 32'(spi_send_axis_tdata), 32'(prev_d));
        check_val("stall_tlast", 32'(spi_send_axis_tlast), 32'(prev_l));
      end
      hs = src_axis_tready & src_axis_tvalid;
      if (spi_send_axis_tvalid && spi_send_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_byte", 32'(spi_send_axis_tdata), 32'h100);
        end else begin
          e = exp_q.pop_front();
          check_val(e.h ? "hdr_byte" : "pay_byte", 32'(spi_send_axis_tdata), 32'(e.d));
          check_val(e.h ? "hdr_tlast" : "pay_tlast", 32'(spi_send_axis_tlast), 32'(e.l));
          if (e.l) last_end = cyc;
        end
        stall_prev = 1'b0;
      end else begin
        stall_prev = spi_send_axis_tvalid;
        prev_d = spi_send_axis_tdata;
        prev_l = spi_send_axis_tlast;
      end
      if (err_len) errs_seen++;
      prev_g = src_grant;
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        @(posedge axi_aclk); #1;
        for (int s = 0; s < N; s++) begin s_act[s] = 1'b0; src_req[s] = 1'b0; end
        drive_sources();
        axi_aresetn = 1'b0;
        @(posedge axi_aclk); #1;
        check_idle_outputs("rst_mid");
        axi_aresetn = 1'b1;
        reset_model();
        return;
      end
      if (exp_q.size() == 0 && ord_q.size() == 0 && !busy) break;
      if (cyc > 3000) begin
        check_val("phase_timeout", cyc, 0);
        break;
      end
      @(posedge axi_aclk); #1;
      for (int s = 0; s < N; s++) begin
        if (prev_g[s]) src_req[s] = 1'b0;
        if (hs[s]) begin
          s_pos[s]++;
          s_vld[s] = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else if (!src_axis_tvalid[s]) begin
          s_vld[s] = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
      spi_send_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_sources();
    end
    check_val("err_len_count", errs_seen, m_errs);
    for (int s = 0; s < N; s++)
      if (cfg_on[s]) check_val("src_consumed", s_pos[s], exp_cons[s]);
    @(posedge axi_aclk); #1;
  endtask

  initial begin
    axi_aresetn = 1'b0;
    src_req = '0; src_type = '0; src_len = '0;
    src_axis_tdata = '0; src_axis_tvalid = '0; src_axis_tlast = '0;
    spi_send_axis_tready = 1'b0;
    for (int s = 0; s < N; s++) begin s_act[s] = 1'b0; s_pos[s] = 0; s_vld[s] = 1'b0; end
    clear_cfg();
    repeat (3) @(posedge axi_aclk);
    #1;
    check_idle_outputs("rst");
    axi_aresetn = 1'b1;
    @(posedge axi_aclk); #1;

    // Single source, ADC data, three bytes
    clear_cfg();
    cfg_on[0] = 1'b1; cfg_type[0] = 8'h12; cfg_len[0] = 3; cfg_lastpos[0] = 3;
    cfg_data[0][0] = 8'hA1; cfg_data[0][1] = 8'hA2; cfg_data[0][2] = 8'hA3;
    run_phase(1'b0, 0);

    // Three simultaneous single-byte requests from a fresh pointer, then src0 again
    do_reset();
    clear_cfg();
    for (int s = 0; s < N; s++) begin
      cfg_on[s] = 1'b1; cfg_len[s] = 1; cfg_lastpos[s] = 1;
      cfg_data[s][0] = 8'(8'hB0 + s);
    end
    cfg_type[0] = 8'h12; cfg_type[1] = 8'h21; cfg_type[2] = 8'h00;
    run_phase(1'b0, 0);
    cfg_on[1] = 1'b0; cfg_on[2] = 1'b0;
    run_phase(1'b0, 0);

    // Zero-length system ack
    clear_cfg();
    cfg_on[2] = 1'b1; cfg_type[2] = 8'h00; cfg_len[2] = 0; cfg_lastpos[2] = 0;
    cfg_data[2][0] = 8'h5A;
    run_phase(1'b0, 0);

    // Early source tlast, then missing source tlast
    clear_cfg();
    cfg_on[1] = 1'b1; cfg_type[1] = 8'h21; cfg_len[1] = 4; cfg_lastpos[1] = 2;
    for (int i = 0; i < 16; i++) cfg_data[1][i] = 8'(8'hC0 + i);
    run_phase(1'b0, 0);
    clear_cfg();
    cfg_on[0] = 1'b1; cfg_type[0] = 8'h12; cfg_len[0] = 2; cfg_lastpos[0] = 0;
    for (int i = 0; i < 16; i++) cfg_data[0][i] = 8'(8'hD0 + i);
    run_phase(1'b0, 0);

    // Reset in the middle of a payload, then a packet that must restart at id 0
    clear_cfg();
    cfg_on[0] = 1'b1; cfg_type[0] = 8'h12; cfg_len[0] = 8; cfg_lastpos[0] = 8;
    for (int i = 0; i < 16; i++) cfg_data[0][i] = 8'(8'hE0 + i);
    run_phase(1'b0, 8);
    clear_cfg();
    cfg_on[1] = 1'b1; cfg_type[1] = 8'h22; cfg_len[1] = 2; cfg_lastpos[1] = 2;
    cfg_data[1][0] = 8'h77; cfg_data[1][1] = 8'h88;
    run_phase(1'b0, 0);

    // Random subsets, lengths, tlast behaviour and backpressure
    for (int ph = 0; ph < 40; ph++) begin
      int on_mask, r;
      clear_cfg();
      on_mask = $urandom_range(1, 7);
      for (int s = 0; s < N; s++) begin
        cfg_on[s]   = on_mask[s];
        cfg_type[s] = 8'($urandom);
        cfg_len[s]  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 10);
        for (int i = 0; i < 16; i++) cfg_data[s][i] = 8'($urandom);
        r = $urandom_range(0, 9);
        if (cfg_len[s] == 0)                  cfg_lastpos[s] = 0;
        else if (r == 0 && cfg_len[s] > 1)    cfg_lastpos[s] = $urandom_range(1, cfg_len[s] - 1);
        else if (r == 1)                      cfg_lastpos[s] = 0;
        else                                  cfg_lastpos[s] = cfg_len[s];
      end
      run_phase(1'b1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
